alb_mp_seq: RTL and testbench
=============================

# alb_mp_seq

- Multi-precision sequencer for the `alb` datapath.
- Accepts a transaction command: operation, word count, initial carry.
- Streams operand word pairs, least-significant word first, into `alb`, chaining `alb`'s carry-out into the next word's carry-in.
- Returns one result word per operand word, then transaction-level flags.
- Sits between a command/operand producer and a single `alb` instance, which it owns exclusively.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the driven `alb`.
- MAX_WORDS, 4, maximum words per transaction (≥2); CW = $clog2(MAX_WORDS).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- op  in  2  `alb` operation code, latched at start, drives `alb_i`.
- nwords_m1  in  CW  word count minus one, latched at start.
- cin  in  1  carry-in for word 0, latched at start.
- busy  out  1  high from the cycle after start through the DONE cycle.
- opnd_valid  in  1  operand pair valid.
- opnd_ready  out  1  high only in RUN.
- opnd_a  in  DATA_WIDTH  operand word.
- opnd_b  in  DATA_WIDTH  operand word.
- res_valid  out  1  result word valid, one-cycle pulse per word; no backpressure.
- res_data  out  DATA_WIDTH  result word.
- res_last  out  1  marks the final result word.
- done  out  1  one-cycle pulse; the flag outputs are valid in this cycle.
- flag_c  out  1  transaction carry flag.
- flag_v  out  1  transaction overflow flag.
- flag_n  out  1  transaction negative flag.
- flag_z  out  1  transaction zero flag.
- alb_a  out  DATA_WIDTH  to `alb` a; combinational copy of opnd_a.
- alb_b  out  DATA_WIDTH  to `alb` b; combinational copy of opnd_b.
- alb_ci  out  1  to `alb` ci, registered.
- alb_i  out  2  to `alb` i, registered.
- alb_f  in  DATA_WIDTH  from `alb`.
- alb_co  in  1  from `alb`.
- alb_vo  in  1  from `alb`.
- alb_no  in  1  from `alb`.
- alb_zo  in  1  from `alb`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches op/nwords_m1/cin, clears the word counter, loads the carry register with cin, sets the zero accumulator to 1, then goes to RUN.
  - RUN: opnd_ready=1. Each handshake (opnd_valid & opnd_ready) increments the counter. The handshake on word nwords_m1 goes to DRAIN.
  - DRAIN: one cycle, then DONE.
  - DONE: one cycle, then IDLE.
- start outside IDLE is ignored.
- Arithmetic ops (op[0]=1):
  - alb_ci = carry register.
  - The carry register updates from alb_co at each sampled word.
- Logic ops (op[0]=0):
  - alb_ci = 0.
  - The carry register is ignored.
  - flag_c and flag_v are forced to 0.
- Flags:
  - flag_z = AND of alb_zo over all words.
  - flag_n = alb_no of the last word.
  - flag_c = alb_co of the last word.
  - flag_v = alb_vo of the last word.
- Transactions with nwords_m1=0 are valid single-word operations.
- Reset (low) in any state:
  - Returns to IDLE and clears the pipeline valid bit.
  - Drops partial results; no res_valid or done follows.
  - The next transaction behaves as if fresh.

## Timing
- `alb` registers a/b on every edge; i/ci and all outputs are combinational from those registers. The required pipeline is therefore:
  - Cycle t: handshake for word k; alb_a/alb_b carry the word; `alb` captures it at the end of t.
  - Cycle t+1: alb_i=op, alb_ci=carry of word k; alb_f/flags sampled at the end of t+1 into res_data and the flag registers, only if the stage-valid bit is set.
  - Cycle t+2: res_valid=1, res_data = result of word k.
- Latency is 2 cycles operand-to-result, with one word per cycle throughput.
- Operand gaps (opnd_valid=0) create bubbles:
  - The stage-valid bit is 0 during a bubble.
  - The carry register and zero accumulator hold.
  - Garbage captured by `alb` is never sampled.
- Last word accepted at cycle t:
  - DRAIN = t+1.
  - DONE = t+2.
  - res_last, done and the flags are all valid at t+2; busy falls at t+3.
- Minimum transaction: start at cycle 0, word accepted at cycle 1, res/done at cycle 3, next start accepted at cycle 4.
- Reset values:
  - busy, opnd_ready, res_valid, res_last, done, flag_c/v/n/z, alb_ci are 0.
  - res_data = 0; alb_i = 0; carry register = 0.
  - alb_a/alb_b are not registered and follow opnd_a/opnd_b.

## Test plan
- 2-word add, op=01, cin=0, words (a,b) = (FF,01),(01,00):
  - Results 00, 02; res_last on the 2nd word.
  - Flags c=0, z=0, n=0.
  - done 2 cycles after the last handshake.
- 4-word add, op=01, cin=0, a=FFFFFFFF, b=00000001:
  - Results 00,00,00,00.
  - Flags c=1, z=1, n=0, v=0.
- 3-word add of 00FFFF + 000001 with opnd_valid low for 3 cycles between words 1 and 2:
  - Results 00,00,01; flag_c=0.
  - The carry survives the gap.
  - res_valid pulses exactly 3 times.
- Subtract, op=11, cin=1, equal 2-word operands 1234/1234:
  - Results 00,00; flag_z=1.
- Reset held low for 1 cycle after the 1st of 4 words:
  - Next cycle busy=0, opnd_ready=0.
  - No further res_valid or done.
  - A following 1-word add 05+03 yields 08 with done at the expected cycle.
- start pulsed during RUN is ignored.
- 1-word logic op (op=00):
  - flag_c=flag_v=0 regardless of alb_co/alb_vo.
  - alb_ci=0 throughout.

Source files
------------

// File: rtl/alb_mp_seq.sv
// Multi-precision sequencer: streams LSW-first operand pairs through one alb, chaining its carry.
// Latency 2 cycles operand-to-result. opnd_ready only in RUN; the result stream has no backpressure.
module alb_mp_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 4,
    localparam int CW        = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [CW-1:0]         nwords_m1,
    input  logic                  cin,
    output logic                  busy,
    input  logic                  opnd_valid,
    output logic                  opnd_ready,
    input  logic [DATA_WIDTH-1:0] opnd_a,
    input  logic [DATA_WIDTH-1:0] opnd_b,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_last,
    output logic                  done,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic [DATA_WIDTH-1:0] alb_a,
    output logic [DATA_WIDTH-1:0] alb_b,
    output logic                  alb_ci,
    output logic [1:0]            alb_i,
    input  logic [DATA_WIDTH-1:0] alb_f,
    input  logic                  alb_co,
    input  logic                  alb_vo,
    input  logic                  alb_no,
    input  logic                  alb_zo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [1:0]            r_op;
    logic [CW-1:0]         r_nm1;
    logic [CW-1:0]         r_cnt;
    logic                  r_carry;
    logic                  r_zacc;
    logic                  r_s1_vld;
    logic                  r_s1_last;
    logic                  r_res_vld;
    logic                  r_res_last;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_flag_c;
    logic                  r_flag_v;
    logic                  r_flag_n;
    logic                  r_flag_z;

    logic w_hs;
    logic w_last;

    assign w_hs   = opnd_valid && (r_state == S_RUN);
    assign w_last = (r_cnt == r_nm1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_nm1      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_zacc     <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_res_vld  <= 1'b0;
            r_res_last <= 1'b0;
            r_res_data <= '0;
            r_flag_c   <= 1'b0;
            r_flag_v   <= 1'b0;
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
        end else begin
            r_s1_vld   <= w_hs;
            r_s1_last  <= w_hs && w_last;
            r_res_vld  <= r_s1_vld;
            r_res_last <= r_s1_vld && r_s1_last;

            // alb outputs are only meaningful one cycle after a real handshake
            if (r_s1_vld) begin
                r_res_data <= alb_f;
                r_carry    <= alb_co & r_op[0];
                r_zacc     <= r_zacc & alb_zo;
                r_flag_z   <= r_zacc & alb_zo;
                r_flag_n   <= alb_no;
                r_flag_c   <= alb_co & r_op[0];
                r_flag_v   <= alb_vo & r_op[0];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_nm1   <= nwords_m1;
                        r_cnt   <= '0;
                        r_carry <= cin & op[0];
                        r_zacc  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign opnd_ready = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign res_valid  = r_res_vld;
    assign res_last   = r_res_last;
    assign res_data   = r_res_data;
    assign flag_c     = r_flag_c;
    assign flag_v     = r_flag_v;
    assign flag_n     = r_flag_n;
    assign flag_z     = r_flag_z;
    // carry register is held at 0 for logic ops, so it can drive ci directly
    assign alb_ci     = r_carry;
    assign alb_i      = r_op;
    assign alb_a      = opnd_a;
    assign alb_b      = opnd_b;

endmodule

// File: tb/tb_alb_mp_seq.sv
// Bench for alb_mp_seq with a behavioural alb and a result/flag scoreboard.
module tb_alb_mp_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [1:0] nwords_m1;
    logic       cin;
    logic       busy;
    logic       opnd_valid;
    logic       opnd_ready;
    logic [7:0] opnd_a, opnd_b;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_last;
    logic       done;
    logic       flag_c, flag_v, flag_n, flag_z;
    logic [7:0] alb_a, alb_b;
    logic       alb_ci;
    logic [1:0] alb_i;
    logic [7:0] alb_f;
    logic       alb_co, alb_vo, alb_no, alb_zo;

    always #5 clk = ~clk;

    alb_mp_seq #(.DATA_WIDTH(8), .MAX_WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .nwords_m1(nwords_m1),
        .cin(cin), .busy(busy), .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .res_valid(res_valid), .res_data(res_data),
        .res_last(res_last), .done(done), .flag_c(flag_c), .flag_v(flag_v),
        .flag_n(flag_n), .flag_z(flag_z), .alb_a(alb_a), .alb_b(alb_b),
        .alb_ci(alb_ci), .alb_i(alb_i), .alb_f(alb_f), .alb_co(alb_co),
        .alb_vo(alb_vo), .alb_no(alb_no), .alb_zo(alb_zo)
    );

    // Behavioural alb: a/b registered every edge, everything else combinational.
    // Logic ops deliberately assert co/vo so the sequencer must mask them.
    logic [7:0] ra, rb;
    always @(posedge clk) begin
        ra <= alb_a;
        rb <= alb_b;
    end
    always_comb begin
        logic [8:0] s;
        logic [7:0] be;
        be     = (alb_i == 2'b11) ? ~rb : rb;
        s      = {1'b0, ra} + {1'b0, be} + {8'd0, alb_ci};
        alb_f  = s[7:0];
        alb_co = s[8];
        alb_vo = (ra[7] == be[7]) && (s[7] != ra[7]);
        if (alb_i == 2'b00) begin
            alb_f  = ra & rb;
            alb_co = 1'b1;
            alb_vo = 1'b1;
        end else if (alb_i == 2'b10) begin
            alb_f  = ra | rb;
            alb_co = 1'b1;
            alb_vo = 1'b1;
        end
        alb_no = alb_f[7];
        alb_zo = (alb_f == 8'd0);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] res_q[$];   // {last, data}
    logic [3:0] flg_q[$];   // {c, v, n, z}
    int  cyc = 0, last_hs = -100, res_cnt = 0, done_cnt = 0;
    bit  chk_ci0 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset && opnd_valid && opnd_ready) last_hs = cyc;
        if (chk_ci0) chk("alb_ci_logic", {31'd0, alb_ci}, 32'd0);
        if (res_valid) begin
            res_cnt++;
            if (res_q.size() == 0) chk("unexpected_res", 32'd1, 32'd0);
            else begin
                logic [8:0] e;
                e = res_q.pop_front();
                chk("res_data", {24'd0, res_data}, {24'd0, e[7:0]});
                chk("res_last", {31'd0, res_last}, {31'd0, e[8]});
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_latency", cyc, last_hs + 2);
            if (flg_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                logic [3:0] f;
                f = flg_q.pop_front();
                chk("flags_cvnz", {28'd0, flag_c, flag_v, flag_n, flag_z}, {28'd0, f});
            end
        end
    end

    task automatic do_start(input logic [1:0] o, input int n, input logic ci);
        @(posedge clk); #1;
        start = 1'b1; op = o; nwords_m1 = 2'(n - 1); cin = ci;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b10; cin = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_txn(input logic [1:0] o, input int n, input logic ci,
                            input logic [31:0] a, input logic [31:0] b,
                            input int gap_at, input int gap_len);
        logic c, z, v, arith;
        logic [8:0] s;
        logic [7:0] aw, bw, r;
        int rc0, dc0;
        arith = o[0];
        c = ci; z = 1'b1; v = 1'b0; r = 8'd0;
        for (int k = 0; k < n; k++) begin
            aw = a[8*k +: 8];
            bw = b[8*k +: 8];
            if (o == 2'b01 || o == 2'b11) begin
                if (o == 2'b11) bw = ~bw;
                s = {1'b0, aw} + {1'b0, bw} + {8'd0, c};
                r = s[7:0];
                c = s[8];
                v = (aw[7] == bw[7]) && (r[7] != aw[7]);
            end else begin
                r = (o == 2'b00) ? (aw & bw) : (aw | bw);
            end
            z = z & (r == 8'd0);
            res_q.push_back({(k == n - 1), r});
        end
        flg_q.push_back({arith & c, arith & v, r[7], z});
        rc0 = res_cnt; dc0 = done_cnt;
        do_start(o, n, ci);
        for (int k = 0; k < n; k++) begin
            opnd_valid = 1'b1;
            opnd_a = a[8*k +: 8];
            opnd_b = b[8*k +: 8];
            if (!opnd_ready) chk("opnd_ready_in_run", 32'd0, 32'd1);
            @(posedge clk); #1;
            opnd_valid = 1'b0;
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    opnd_a = 8'hA5; opnd_b = 8'h5A;
                    start = (g == 0);          // start during RUN must be ignored
                    op = 2'b00;
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("res_count", res_cnt - rc0, n);
        chk("done_count", done_cnt - dc0, 1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("res_q_empty", res_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; nwords_m1 = 2'd0; cin = 1'b0;
        opnd_valid = 1'b0; opnd_a = 8'h3C; opnd_b = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, opnd_ready}, 32'd0);
        chk("rst_res", {22'd0, res_valid, res_last, res_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {28'd0, flag_c, flag_v, flag_n, flag_z}, 32'd0);
        chk("rst_alb_ctl", {29'd0, alb_ci, alb_i}, 32'd0);
        chk("rst_alb_ab", {16'd0, alb_a, alb_b}, 32'h3CC3);
        reset = 1'b1;

        send_txn(2'b01, 2, 1'b0, 32'h000001FF, 32'h00000001, -1, 0);
        send_txn(2'b01, 4, 1'b0, 32'hFFFFFFFF, 32'h00000001, -1, 0);
        send_txn(2'b01, 3, 1'b0, 32'h0000FFFF, 32'h00000001, 1, 3);
        send_txn(2'b11, 2, 1'b1, 32'h00001234, 32'h00001234, -1, 0);
        send_txn(2'b01, 1, 1'b0, 32'h0000007F, 32'h00000001, -1, 0);
        send_txn(2'b11, 3, 1'b1, 32'h00010000, 32'h00000001, 0, 1);

        // Reset mid-transaction after the first of four words
        begin
            int rc0, dc0;
            rc0 = res_cnt; dc0 = done_cnt;
            do_start(2'b01, 4, 1'b0);
            opnd_valid = 1'b1; opnd_a = 8'h11; opnd_b = 8'h22;
            @(posedge clk); #1;
            opnd_valid = 1'b0; reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_ready", {31'd0, opnd_ready}, 32'd0);
            repeat (6) @(posedge clk);
            #1;
            chk("post_rst_res_count", res_cnt - rc0, 0);
            chk("post_rst_done_count", done_cnt - dc0, 0);
        end
        send_txn(2'b01, 1, 1'b0, 32'h00000005, 32'h00000003, -1, 0);

        chk_ci0 = 1'b1;
        send_txn(2'b00, 1, 1'b1, 32'h000000F0, 32'h0000003C, -1, 0);
        send_txn(2'b10, 2, 1'b1, 32'h00008001, 32'h00000100, -1, 0);
        chk_ci0 = 1'b0;

        for (int t = 0; t < 4; t++) begin
            logic [1:0] ro;
            ro = (t[0]) ? 2'b11 : 2'b01;
            send_txn(ro, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
